// File: rtl/uio_bus_arbiter.sv
// uio_bus_arbiter: round-robin owner of the shared 8-bit uio pad bus with all-input turnaround.
// Define UIO_ARB_TIMEOUT_EN to force a release after MAX_HOLD owned beats.
module uio_bus_arbiter #(
  parameter int NREQ     = 2,
  parameter int TURN_CYC = 1,
  parameter int MAX_HOLD = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ-1:0]   last,
  input  logic [NREQ*8-1:0] dout,
  input  logic [NREQ*8-1:0] doe_mask,
  output logic [NREQ-1:0]   gnt,
  output logic [7:0]        uio_out,
  output logic [7:0]        uio_oe,
  output logic              busy,
  output logic              timeout_pulse
);

  localparam int IW = (NREQ > 2) ? 2 : 1;
  localparam logic [7:0]    TURN_LAST = 8'(TURN_CYC - 1);
  localparam logic [IW-1:0] PTR_RST   = IW'(NREQ - 1);

  if (NREQ < 2 || NREQ > 4 || TURN_CYC < 1 || TURN_CYC > 3 ||
      MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_param
    $error("uio_bus_arbiter: parameter out of legal range");
  end

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_OWN, S_RELEASE} state_t;

  state_t            state_q, state_d;
  logic [IW-1:0]     owner_q, owner_d;
  logic [IW-1:0]     ptr_q, ptr_d;
  logic [IW-1:0]     win;
  logic [7:0]        turn_q, turn_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic [7:0]        uio_out_q, uio_out_d;
  logic [7:0]        uio_oe_q, uio_oe_d;
  logic              busy_q, busy_d;
  logic [2*NREQ-1:0] req_rot;
  int                off;
  logic              rel_last, rel_drop, rel_to;

`ifdef UIO_ARB_TIMEOUT_EN
  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);
  logic [7:0] hold_q, hold_d;
  logic       tpulse_q, tpulse_d;
`endif

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Rotate so that bit 0 is requester ptr+1; the lowest set bit is the winner.
  always_comb begin
    req_rot = {req, req} >> (int'(ptr_q) + 1);
    off = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req_rot[k]) off = k;
    end
    win = IW'((int'(ptr_q) + 1 + off) % NREQ);
  end

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    ptr_d     = ptr_q;
    turn_d    = turn_q;
    gnt_d     = '0;
    uio_out_d = 8'h00;
    uio_oe_d  = 8'h00;
    rel_last  = last[owner_q];
    rel_drop  = ~req[owner_q];
`ifdef UIO_ARB_TIMEOUT_EN
    hold_d    = hold_q;
    tpulse_d  = 1'b0;
    rel_to    = (hold_q == HOLD_LAST);
`else
    rel_to    = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (|req) begin
          owner_d = win;
          ptr_d   = win;
          turn_d  = 8'd0;
          state_d = S_SETUP;
        end
      end
      S_SETUP: begin
        if (turn_q == TURN_LAST) begin
          state_d = S_OWN;
`ifdef UIO_ARB_TIMEOUT_EN
          hold_d  = 8'd0;
`endif
        end else begin
          turn_d = sat_inc(turn_q);
        end
      end
      S_OWN: begin
        // The beat that carries last or the req drop is still driven.
        gnt_d[owner_q] = 1'b1;
        uio_out_d      = dout[int'(owner_q)*8 +: 8];
        uio_oe_d       = doe_mask[int'(owner_q)*8 +: 8];
`ifdef UIO_ARB_TIMEOUT_EN
        hold_d         = sat_inc(hold_q);
`endif
        if (rel_last || rel_drop || rel_to) begin
          state_d = S_RELEASE;
          turn_d  = 8'd0;
`ifdef UIO_ARB_TIMEOUT_EN
          tpulse_d = rel_to & ~rel_last & ~rel_drop;
`endif
        end
      end
      S_RELEASE: begin
        if (turn_q == TURN_LAST) begin
          state_d = S_IDLE;
        end else begin
          turn_d = sat_inc(turn_q);
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      owner_q   <= '0;
      ptr_q     <= PTR_RST;
      turn_q    <= 8'd0;
      gnt_q     <= '0;
      uio_out_q <= 8'h00;
      uio_oe_q  <= 8'h00;
      busy_q    <= 1'b0;
`ifdef UIO_ARB_TIMEOUT_EN
      hold_q    <= 8'd0;
      tpulse_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      ptr_q     <= ptr_d;
      turn_q    <= turn_d;
      gnt_q     <= gnt_d;
      uio_out_q <= uio_out_d;
      uio_oe_q  <= uio_oe_d;
      busy_q    <= busy_d;
`ifdef UIO_ARB_TIMEOUT_EN
      hold_q    <= hold_d;
      tpulse_q  <= tpulse_d;
`endif
    end
  end

  assign gnt     = gnt_q;
  assign uio_out = uio_out_q;
  assign uio_oe  = uio_oe_q;
  assign busy    = busy_q;
`ifdef UIO_ARB_TIMEOUT_EN
  assign timeout_pulse = tpulse_q;
`else
  assign timeout_pulse = 1'b0;
`endif

endmodule

// File: tb/tb_uio_bus_arbiter.sv
// Scoreboard bench for uio_bus_arbiter: random requester agents, an edge-timeline reference
// model that predicts every owned pad beat, and a decoupled monitor that pops and compares.
module tb_uio_bus_arbiter;

  localparam int NREQ = 2;
  localparam int TCYC = 1;
  localparam int MAXH = 16;
`ifdef UIO_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req, last, gnt;
  logic [NREQ*8-1:0] dout, doe_mask;
  logic [7:0]        uio_out, uio_oe;
  logic              busy, timeout_pulse;

  uio_bus_arbiter #(.NREQ(NREQ), .TURN_CYC(TCYC), .MAX_HOLD(MAXH)) dut (
    .clk           (clk),
    .rst           (rst),
    .req           (req),
    .last          (last),
    .dout          (dout),
    .doe_mask      (doe_mask),
    .gnt           (gnt),
    .uio_out       (uio_out),
    .uio_oe        (uio_oe),
    .busy          (busy),
    .timeout_pulse (timeout_pulse)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         stamp;
    int         owner;
    logic [7:0] d;
    logic [7:0] oe;
  } beat_t;

  beat_t exp_q[$];
  bit    exp_busy[int];
  bit    exp_tp[int];
  int    cyc = 0;
  int    n_cmp = 0;
  int    n_bad = 0;
  bit    fin_req = 1'b0;
  beat_t mb;

  // reference model: owner, first owned edge, first edge arbitration may happen, pointer
  int m_owner, m_own_from, m_free, m_ptr;
  // requester agents and phase knobs
  bit            a_act[NREQ];
  int            a_len[NREQ];
  bit            a_drop[NREQ];
  logic [NREQ-1:0] ph_en;
  int            ph_hog, ph_len;
  bit            ph_drop, ph_fix, ph_cont;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (cyc >= 1) begin
      if (exp_busy.exists(cyc)) chk("busy", 32'(busy), 32'(exp_busy[cyc]));
      chk("timeout_pulse", 32'(timeout_pulse), 32'(exp_tp.exists(cyc)));
      if (gnt != '0 || uio_oe != 8'h00) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_beat at cycle %0d: gnt %0h oe %0h with nothing expected",
                   cyc, gnt, uio_oe);
        end else begin
          mb = exp_q.pop_front();
          chk("beat_cycle", 32'(cyc), 32'(mb.stamp));
          chk("gnt", 32'(gnt), 32'(1 << mb.owner));
          chk("uio_out", 32'(uio_out), 32'(mb.d));
          chk("uio_oe", 32'(uio_oe), 32'(mb.oe));
        end
      end else begin
        chk("idle_uio_out", 32'(uio_out), 32'd0);
        if (exp_q.size() != 0 && exp_q[0].stamp <= cyc) begin
          mb = exp_q.pop_front();
          n_cmp++;
          n_bad++;
          $display("FAIL missing_beat at cycle %0d: pads idle, expected owner %0d data %0h",
                   cyc, mb.owner, mb.d);
        end
      end
      if (fin_req) begin
        chk("leftover_beats", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
      end
    end
  end

  task automatic model_edge(input int e, input bit r, input logic [NREQ-1:0] rq,
                            input logic [NREQ-1:0] lst, input logic [NREQ*8-1:0] dv,
                            input logic [NREQ*8-1:0] ov);
    beat_t b;
    bit    rel, to;
    int    w;
    if (r) begin
      m_owner = -1;
      m_ptr = NREQ - 1;
      m_free = e + 1;
      exp_busy[e] = 1'b0;
      return;
    end
    if (m_owner >= 0 && e >= m_own_from) begin
      b.stamp = e;
      b.owner = m_owner;
      b.d = dv[m_owner*8 +: 8];
      b.oe = ov[m_owner*8 +: 8];
      exp_q.push_back(b);
      rel = lst[m_owner] || !rq[m_owner];
      to = TO_EN && !rel && (e - m_own_from + 1 >= MAXH);
      if (rel || to) begin
        m_owner = -1;
        m_free = e + TCYC + 1;
        if (to) exp_tp[e] = 1'b1;
      end
    end else if (m_owner < 0 && e >= m_free && rq != '0) begin
      w = -1;
      for (int k = 1; k <= NREQ; k++) begin
        if (w < 0 && rq[(m_ptr + k) % NREQ]) w = (m_ptr + k) % NREQ;
      end
      m_owner = w;
      m_ptr = w;
      m_own_from = e + TCYC + 1;
    end
    exp_busy[e] = (m_owner >= 0) || (e < m_free - 1);
  endtask

  task automatic drive_cycle(input bit rst_v);
    int e, beat;
    logic [NREQ-1:0]   rq, lst;
    logic [NREQ*8-1:0] dv, ov;
    @(negedge clk);
    e = cyc + 1;
    for (int i = 0; i < NREQ; i++) begin
      beat = (!rst_v && m_owner == i && e >= m_own_from) ? e - m_own_from + 1 : 0;
      if (!a_act[i] && ph_en[i] && (ph_cont || $urandom_range(0, 2) == 0)) begin
        a_act[i] = 1'b1;
        a_len[i] = (i == ph_hog) ? 1000 : ((ph_len > 0) ? ph_len : int'($urandom_range(1, 4)));
        a_drop[i] = ph_drop && ($urandom_range(0, 3) == 0);
      end
      rq[i] = a_act[i];
      lst[i] = (m_owner == i) ? 1'b0 : 1'($urandom_range(0, 1));
      if (beat != 0 && beat >= a_len[i]) begin
        if (a_drop[i]) rq[i] = 1'b0;
        else lst[i] = 1'b1;
        a_act[i] = 1'b0;
      end
      if (ph_fix) begin
        dv[i*8 +: 8] = (i == 0) ? 8'hA5 : 8'h5A;
        ov[i*8 +: 8] = (i == 0) ? 8'hFF : 8'h0F;
      end else begin
        dv[i*8 +: 8] = 8'($urandom);
        ov[i*8 +: 8] = 8'($urandom);
      end
    end
    rst = rst_v;
    req = rq;
    last = lst;
    dout = dv;
    doe_mask = ov;
    model_edge(e, rst_v, rq, lst, dv, ov);
  endtask

  task automatic set_phase(input logic [NREQ-1:0] en, input int hog, input int len,
                           input bit drp, input bit fix, input bit cont);
    ph_en = en;
    ph_hog = hog;
    ph_len = len;
    ph_drop = drp;
    ph_fix = fix;
    ph_cont = cont;
    for (int i = 0; i < NREQ; i++) begin
      if (i != hog && a_len[i] >= 1000) begin
        a_len[i] = 1;
        a_drop[i] = 1'b1;
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    req = '0;
    last = '0;
    dout = '0;
    doe_mask = '0;
    m_owner = -1;
    m_ptr = NREQ - 1;
    m_free = 0;
    m_own_from = 0;
    for (int i = 0; i < NREQ; i++) begin
      a_act[i] = 1'b0;
      a_len[i] = 0;
      a_drop[i] = 1'b0;
    end
    set_phase('0, -1, 0, 1'b0, 1'b0, 1'b0);
    repeat (5) drive_cycle(1'b1);

    // requester 0 alone, fixed 3-beat bursts of A5/FF
    set_phase(2'b01, -1, 3, 1'b0, 1'b1, 1'b0);
    repeat (30) drive_cycle(1'b0);

    // both requesting continuously with 2-beat bursts: strict alternation
    set_phase(2'b11, -1, 2, 1'b0, 1'b0, 1'b1);
    repeat (40) drive_cycle(1'b0);

    // requester 1 never ends its burst; requester 0 asks occasionally
    set_phase(2'b11, 1, 2, 1'b0, 1'b0, 1'b0);
    repeat (140) drive_cycle(1'b0);
    for (int k = 0; k < 200 && !(m_owner == 1 && cyc + 1 >= m_own_from + 2); k++)
      drive_cycle(1'b0);

    // one-cycle reset in the middle of requester 1's ownership, then both request
    drive_cycle(1'b1);
    set_phase(2'b11, -1, 2, 1'b0, 1'b0, 1'b1);
    repeat (20) drive_cycle(1'b0);

    // random bursts, some ending by dropping req instead of last
    set_phase(2'b11, -1, 0, 1'b1, 1'b0, 1'b0);
    repeat (300) drive_cycle(1'b0);

    set_phase('0, -1, 0, 1'b0, 1'b0, 1'b0);
    repeat (40) drive_cycle(1'b0);

    @(posedge clk);
    fin_req = 1'b1;
    repeat (4) @(negedge clk);
    $display("FAIL finish_timeout: monitor did not close the run");
    $fatal(1, "bench did not terminate");
  end

endmodule

// File: doc/uio_bus_arbiter.md
# uio_bus_arbiter

Round-robin arbiter that shares the 8-bit bidirectional `uio` pad bus of the tile among `NREQ` internal requesters. It grants exclusive ownership for a burst, muxes the owner's data and per-bit output enables onto `uio_out`/`uio_oe`, and inserts all-input turnaround cycles between owners so two drivers never contend on the pads. It sits between the user datapath blocks and the top-level `uio_out`/`uio_oe` ports.

## Interface
Parameters:
- `NREQ`, 2: number of requesters, legal range 2..4.
- `TURN_CYC`, 1: turnaround cycles with `uio_oe`=0 before and after each ownership, legal range 1..3.
- `MAX_HOLD`, 16: maximum OWN cycles per grant when the timeout is compiled in, legal range 2..255.

Ports:
- Clocking and reset: one clock; reset is synchronous and active-high.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req`  in  NREQ  per-requester request level.
- `last`  in  NREQ  per-requester final-beat flag; sampled only for the current owner.
- `dout`  in  NREQ*8  per-requester data; requester i occupies bits [8i+7:8i].
- `doe_mask`  in  NREQ*8  per-requester output enables, packed the same way as `dout`.
- `gnt`  out  NREQ  one-hot grant; high only in OWN.
- `uio_out`  out  8  pad output data.
- `uio_oe`  out  8  pad output enable (1 = drive).
- `busy`  out  1  high in any state other than IDLE.
- `timeout_pulse`  out  1  one-cycle flag on a forced release.

## Operation
- FSM states: IDLE, SETUP, OWN, RELEASE.
- IDLE: if any `req` bit is set, select the winner, latch it as `owner`, clear the turn counter, and go to SETUP. Otherwise stay in IDLE.
- Winner selection: search starts at `ptr+1` and wraps modulo NREQ; the first set `req` bit wins. `ptr` updates to the winner at grant time.
- SETUP: hold for `TURN_CYC` cycles, then go to OWN and clear the hold counter.
- OWN: `gnt[owner]`=1, `uio_out`=`dout[owner]`, `uio_oe`=`doe_mask[owner]`, and the hold counter increments each cycle.
- OWN exits to RELEASE on whichever of these occurs first:
  - `last[owner]`=1: that beat is still driven, then release.
  - `req[owner]`=0: release immediately; that cycle is still driven.
  - Timeout (only when compiled in).
- RELEASE: hold for `TURN_CYC` cycles, then return to IDLE. Arbitration resumes from IDLE, so each handover costs 1 + 2·`TURN_CYC` idle cycles.
- Outside OWN: `gnt`=0, `uio_out`=0, `uio_oe`=0.
- All pad outputs are registered; no combinational path from `dout` to `uio_out`.
- Counters are 8 bits wide and saturate; they never wrap.
- Requests arriving during SETUP, OWN or RELEASE do not preempt the owner. They are only evaluated in IDLE.
- Simultaneous `last` and timeout in the same cycle: treat as a normal release; `timeout_pulse` stays 0.

## Timing
- Reset values: `gnt`=0, `uio_out`=0, `uio_oe`=0, `busy`=0, `timeout_pulse`=0, state IDLE, `ptr`=NREQ-1 (requester 0 wins first), counters 0.
- Reset asserted mid-burst: on the next edge all outputs reach their reset values, regardless of state.
- Latency: `req` high in IDLE at edge n → SETUP for edges n+1..n+TURN_CYC → registered outputs show OWN (`gnt`, `uio_oe`) after edge n+1+TURN_CYC.
- Release latency: `last` sampled at edge m → `gnt`/`uio_oe` read 0 after edge m+1.
- `busy` rises with the transition to SETUP and falls on entry to IDLE.

## Configuration
- Macro: `UIO_ARB_TIMEOUT_EN`.
- Defined: when the hold counter reaches `MAX_HOLD` in OWN, the block forces the transition to RELEASE. `timeout_pulse` is high for exactly the first RELEASE cycle.
- Undefined:
  - no forced release; ownership lasts until `last` or the `req` drop;
  - `timeout_pulse` is tied 0;
  - the hold counter is removed.

## Test plan
- Reset with `req`=0 for 5 cycles → `gnt`=0, `uio_oe`=0x00, `uio_out`=0x00, `busy`=0 on every cycle.
- NREQ=2, TURN_CYC=1. Requester 0 sets `req0`=1, `dout0`=0xA5, `doe_mask0`=0xFF, and pulses `last0` on its 3rd OWN beat → `gnt`=01 starting 2 cycles after `req`, `uio_out`=0xA5 and `uio_oe`=0xFF for exactly 3 cycles, then 1 RELEASE cycle with `uio_oe`=0.
- Both requesters hold `req` continuously, each with 2-beat bursts → grant order 0,1,0,1; `uio_oe`=0 for ≥3 cycles between every pair of owners; `gnt` is never 11.
- With `UIO_ARB_TIMEOUT_EN` and MAX_HOLD=16, requester 1 holds `req` with no `last` → exactly 16 OWN cycles, `timeout_pulse` high for 1 cycle, and requester 0 (if requesting) is granted next. With the macro undefined, ownership persists for more than 100 cycles.
- Assert `rst` for one cycle during OWN of requester 1 → outputs are 0 on the next edge; with both `req` bits then set, requester 0 is granted first.
- Owner drops `req` mid-burst without `last` → release the next cycle and `uio_oe`=0; `timeout_pulse`=0.
